// File: rtl/pipe_reg_rv.sv
// Ready/valid pipeline register chain with flush and occupancy count.
// Optional per-stage skid slots with registered ready: define PIPE_REG_RV_SKID_EN.
module pipe_reg_rv #(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             flush,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [WIDTH-1:0]                 in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WIDTH-1:0]                 out_data,
  output logic [$clog2(2*DEPTH+1)-1:0]     level
);

  localparam int LW = $clog2(2*DEPTH+1);

  logic [DEPTH-1:0] r_m_valid;
  logic [WIDTH-1:0] r_m_data [DEPTH];
  logic             r_rst_done;
  logic [LW-1:0]    r_level;
  logic [DEPTH:0]   w_rdy;
  logic [DEPTH-1:0] w_up_valid;
  logic [WIDTH-1:0] w_up_data [DEPTH];
  logic             w_push;
  logic             w_pop;

  assign out_valid = r_m_valid[DEPTH-1];
  assign out_data  = r_m_data[DEPTH-1];
  assign level     = r_level;
  assign in_ready  = r_rst_done && !flush && w_rdy[0];
  assign w_push    = in_valid && in_ready;
  // A flush swallows a simultaneous out_ready: nothing leaves that cycle.
  assign w_pop     = out_valid && out_ready && !flush;

  // Payload offered to each stage: the input port for stage 0, else the previous main slot.
  always_comb begin
    w_up_valid    = '0;
    w_up_valid[0] = w_push;
    w_up_data[0]  = in_data;
    for (int k = 1; k < DEPTH; k++) begin
      w_up_valid[k] = r_m_valid[k-1];
      w_up_data[k]  = r_m_data[k-1];
    end
  end

  // Held off for one clock after reset so in_ready is low throughout reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rst_done <= 1'b0;
    end else begin
      r_rst_done <= 1'b1;
    end
  end

  // Occupancy: +1 per transfer in, -1 per transfer out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_level <= '0;
    end else if (flush) begin
      r_level <= '0;
    end else if (w_push && !w_pop) begin
      r_level <= r_level + LW'(1);
    end else if (!w_push && w_pop) begin
      r_level <= r_level - LW'(1);
    end else begin
      r_level <= r_level;
    end
  end

`ifdef PIPE_REG_RV_SKID_EN
  logic [DEPTH-1:0] r_s_valid;
  logic [WIDTH-1:0] r_s_data [DEPTH];

  // A stage takes new input only while its skid slot is empty, so ready is a pure flop output.
  always_comb begin
    w_rdy = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_rdy[k] = !r_s_valid[k];
    end
    w_rdy[DEPTH] = out_ready;
  end

  // Main slot refills from the skid slot first; an arrival that cannot enter main parks in skid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_m_valid <= '0;
      r_s_valid <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_m_data[k] <= RESET_VAL;
        r_s_data[k] <= RESET_VAL;
      end
    end else if (flush) begin
      r_m_valid <= '0;
      r_s_valid <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_m_data[k] <= RESET_VAL;
        r_s_data[k] <= RESET_VAL;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (!r_m_valid[k] || w_rdy[k+1]) begin
          if (r_s_valid[k]) begin
            r_m_valid[k] <= 1'b1;
            r_m_data[k]  <= r_s_data[k];
            r_s_valid[k] <= 1'b0;
          end else begin
            r_m_valid[k] <= w_up_valid[k] && w_rdy[k];
            if (w_up_valid[k] && w_rdy[k]) begin
              r_m_data[k] <= w_up_data[k];
            end
          end
        end else if (w_up_valid[k] && w_rdy[k]) begin
          r_s_valid[k] <= 1'b1;
          r_s_data[k]  <= w_up_data[k];
        end
      end
    end
  end
`else
  // Combinational ready chain from out_ready back to stage 0.
  always_comb begin
    w_rdy        = '0;
    w_rdy[DEPTH] = out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      w_rdy[k] = !r_m_valid[k] || w_rdy[k+1];
    end
  end

  // Each stage reloads whenever it is empty or its contents move downstream.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_m_valid <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_m_data[k] <= RESET_VAL;
      end
    end else if (flush) begin
      r_m_valid <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_m_data[k] <= RESET_VAL;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (w_rdy[k]) begin
          r_m_valid[k] <= w_up_valid[k];
          if (w_up_valid[k]) begin
            r_m_data[k] <= w_up_data[k];
          end
        end
      end
    end
  end
`endif

endmodule
